seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 5: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 5'b11001: target sequence; PATTERN[PAT_W-1] is the first bit received.
REQ-003 SHALL have parameter CNT_W, default 8: detection counter width.
REQ-004 SHALL have port clk, input, 1: single clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port din, input, 1: serial data bit, sampled on the rising edge of clk.
REQ-007 SHALL have port en, input, 1: bit-valid qualifier; din is consumed only when en=1.
REQ-008 SHALL have port ovl_mode, input, 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 SHALL have port y, output, 1: Mealy detect, combinational from the state, din and en.
REQ-010 SHALL have port y_q, output, 1: y registered, a one-cycle pulse in the cycle after a detection.
REQ-011 SHALL have port cnt_clr, input, 1: synchronous detection-counter clear (only with SEQDET_COUNT_EN).
REQ-012 SHALL have port det_cnt, output, CNT_W: detection count (only with SEQDET_COUNT_EN).

Function
REQ-013 SHALL hold state S in 0..PAT_W-1, binary-encoded in clog2(PAT_W) bits; S is the length of the longest prefix of PATTERN that is a suffix of the consumed bits.
REQ-014 SHALL derive all next-state transitions from PATTERN at elaboration (KMP prefix/failure function); no hand-coded per-pattern state table.
REQ-015 SHALL, on en=1 with din matching the next pattern bit and S<PAT_W-1, advance S to S+1.
REQ-016 SHALL, on en=1 with a mismatch, move to the longest border of the consumed prefix plus din that is a prefix of PATTERN (possibly 0).
REQ-017 SHALL drive y=1 exactly when en=1, S=PAT_W-1 and din=PATTERN[0]; y SHALL be 0 otherwise, including the whole time reset is high.
REQ-018 SHALL, on a detection, set next S to the length of the longest proper border of PATTERN when ovl_mode=1, or to 0 when ovl_mode=0.
REQ-019 SHALL, with en=0, hold S, drive y=0 and leave det_cnt unchanged.
REQ-020 SHALL sample ovl_mode every cycle; a change affects only the next detection, and S is kept.
REQ-021 SHALL set y_q on each clk edge to the value y had before that edge.
REQ-022 SHALL increment det_cnt by 1 per detection and saturate at 2^CNT_W-1 (no wrap).
REQ-023 SHALL, when cnt_clr=1, load det_cnt=0; if cnt_clr and a detection occur in the same cycle, cnt_clr wins and the result is 0.

Reset
REQ-024 SHALL, while reset=1, immediately force S=0, y_q=0 and det_cnt=0, independent of clk.
REQ-025 SHALL discard any partial match when reset is asserted mid-sequence; matching restarts from S=0 with the first enabled bit after release.

Configuration
REQ-026 SHALL compile cnt_clr, det_cnt and the counter logic only when macro SEQDET_COUNT_EN is defined; without it those ports do not exist, and y and y_q behaviour is identical.

Verification
REQ-027 SHALL cover: default params, ovl_mode=1, en=1, din 1,1,0,0,1,1,0,0,1 -> y=1 on the 5th and 9th bits; det_cnt=2.
REQ-028 SHALL cover: same stream with ovl_mode=0 -> y=1 on the 5th bit only; det_cnt=1.
REQ-029 SHALL cover: PAT_W=4, PATTERN=4'b1010, din 1,0,1,0,1,0,1,0 -> y on bits 4, 6, 8 with ovl_mode=1; on bits 4 and 8 with ovl_mode=0.
REQ-030 SHALL cover: default params, din 1,1,0,0 with en=1, then en=0 for 3 cycles with din toggling, then din=1 with en=1 -> y=0 while en=0 and y=1 on the resuming bit; y_q=1 in the following cycle.
REQ-031 SHALL cover: reset pulsed between the 4th and 5th bits of 11001 -> no detection on the 5th bit; the next full 11001 is detected.
REQ-032 SHALL cover: CNT_W=2 with 5 detections -> det_cnt stays 3; cnt_clr asserted in a detection cycle -> det_cnt=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Parameterised serial pattern detector. The state S is the length of the
// longest prefix of PATTERN that is a suffix of the bits consumed so far.
// The transition tables are derived from PATTERN at elaboration with a
// KMP-style prefix/border search. There is no hand-written per-pattern state
// table.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  target sequence; PATTERN[PAT_W-1] is the first bit received
//   CNT_W    detection counter width
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   din       serial data bit
//   en        bit-valid qualifier; din is consumed only when en=1
//   ovl_mode  1 = overlapping detection, 0 = non-overlapping detection
//   y         Mealy detect (combinational from state, din and en)
//   y_q       y registered (one-cycle pulse after a detection)
//   cnt_clr   synchronous counter clear          (SEQDET_COUNT_EN only)
//   det_cnt   saturating detection count         (SEQDET_COUNT_EN only)
//
// Configuration macro: SEQDET_COUNT_EN adds cnt_clr, det_cnt and the counter.
// -----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int unsigned        PAT_W   = 5,
  parameter logic [PAT_W-1:0]   PATTERN = 5'b11001,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  input  logic             ovl_mode,
  output logic             y,
  output logic             y_q
`ifdef SEQDET_COUNT_EN
  ,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] det_cnt
`endif
);

  localparam int unsigned SW = $clog2(PAT_W);
  localparam int unsigned NS = 2 ** SW;

  // Next state after consuming bit b in state s: the longest k such that the
  // first k pattern bits equal the last k bits of (pattern[0..s-1], b).
  // k is capped at PAT_W-1, so for a completed match this yields the longest
  // proper border of the whole pattern.
  function automatic int kmp_next(input int s, input logic b);
    int   best;
    int   kmax;
    int   p;
    logic ok;
    logic tbit;
    best = 0;
    kmax = (s + 1 < int'(PAT_W)) ? s + 1 : int'(PAT_W) - 1;
    for (int k = 1; k <= kmax; k++) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) begin
        p    = s + 1 - k + j;
        tbit = (p < s) ? PATTERN[int'(PAT_W) - 1 - p] : b;
        if (PATTERN[int'(PAT_W) - 1 - j] != tbit) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        best = k;
      end
    end
    return best;
  endfunction

  localparam logic [SW-1:0] LAST_S   = SW'(PAT_W - 1);
  localparam logic [SW-1:0] BORDER_S = SW'(kmp_next(int'(PAT_W) - 1, PATTERN[0]));

  // Parameter sanity check at elaboration.
  if (PAT_W < 2 || PAT_W > 16 || CNT_W < 1) begin : g_bad_param
    $error("seq_detector_param: PAT_W must be 2..16 and CNT_W >= 1");
  end

  typedef logic [SW-1:0] state_t;

  state_t state_q;
  state_t state_d;
  logic   y_s;

  // Transition tables indexed by state, one per input bit value. Entries for
  // unreachable encodings (S >= PAT_W) return to the idle state.
  state_t nxt0_s [NS];
  state_t nxt1_s [NS];

  for (genvar g = 0; g < NS; g++) begin : g_tab
    if (g < PAT_W) begin : g_live
      localparam state_t N0 = SW'(kmp_next(g, 1'b0));
      localparam state_t N1 = SW'(kmp_next(g, 1'b1));
      assign nxt0_s[g] = N0;
      assign nxt1_s[g] = N1;
    end else begin : g_pad
      assign nxt0_s[g] = '0;
      assign nxt1_s[g] = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Mealy detect.
  always_comb begin
    state_d = state_q;
    y_s     = 1'b0;
    if (en) begin
      if ((state_q == LAST_S) && (din == PATTERN[0])) begin
        y_s = 1'b1;
        // ovl_mode is sampled only here, so a change never disturbs S.
        if (ovl_mode) begin
          state_d = BORDER_S;
        end else begin
          state_d = '0;
        end
      end else if (din) begin
        state_d = nxt1_s[state_q];
      end else begin
        state_d = nxt0_s[state_q];
      end
    end else begin
      state_d = state_q;
    end
  end

  // Gating with reset keeps y low for the whole reset interval.
  assign y = y_s & ~reset;

  // Registered copy of the detect pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q <= 1'b0;
    end else begin
      y_q <= y;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] det_cnt_q;
  logic [CNT_W-1:0] det_cnt_d;

  // Saturating counter next value; clear has priority over a detection.
  always_comb begin
    det_cnt_d = det_cnt_q;
    if (cnt_clr) begin
      det_cnt_d = '0;
    end else if (y_s && (det_cnt_q != {CNT_W{1'b1}})) begin
      det_cnt_d = det_cnt_q + CNT_W'(1);
    end else begin
      det_cnt_d = det_cnt_q;
    end
  end

  // Detection counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_cnt_q <= '0;
    end else begin
      det_cnt_q <= det_cnt_d;
    end
  end

  assign det_cnt = det_cnt_q;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Scoreboard bench for seq_detector_param. The stimulus pushes the expected
// y / y_q (and optionally det_cnt) for each observed cycle. A monitor pops
// and compares on the falling edge. dut_a uses the default parameters.
// dut_b uses PAT_W=4, PATTERN=1010. dut_c (counter builds only) uses CNT_W=2.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic ovl_mode = 1'b1;
  logic cnt_clr = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic en_c = 1'b0;
  logic obs = 1'b0;

  logic y_a, yq_a, y_b, yq_b;
  logic [7:0] cnt_a, cnt_b;
  logic y_c, yq_c;
  logic [1:0] cnt_c;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_a (
    .clk(clk), .reset(reset), .din(din), .en(en_a), .ovl_mode(ovl_mode),
    .y(y_a), .y_q(yq_a)
`ifdef SEQDET_COUNT_EN
    , .cnt_clr(cnt_clr), .det_cnt(cnt_a)
`endif
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010)) dut_b (
    .clk(clk), .reset(reset), .din(din), .en(en_b), .ovl_mode(ovl_mode),
    .y(y_b), .y_q(yq_b)
`ifdef SEQDET_COUNT_EN
    , .cnt_clr(cnt_clr), .det_cnt(cnt_b)
`endif
  );

`ifdef SEQDET_COUNT_EN
  seq_detector_param #(.CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .din(din), .en(en_c), .ovl_mode(ovl_mode),
    .y(y_c), .y_q(yq_c), .cnt_clr(cnt_clr), .det_cnt(cnt_c)
  );
`else
  assign cnt_a = 8'd0;
  assign cnt_b = 8'd0;
  assign y_c   = 1'b0;
  assign yq_c  = 1'b0;
  assign cnt_c = 2'd0;
`endif

  typedef struct {
    logic [1:0] sel;
    logic       exp_y;
    logic       exp_yq;
    logic       chk_cnt;
    logic [7:0] exp_cnt;
    string      name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare one scoreboard entry per observed cycle.
  always @(negedge clk) begin
    if (obs) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 8'd1, 8'd0);
      end else begin
        exp_t e;
        logic ay, ayq;
        logic [7:0] acnt;
        e = sb.pop_front();
        case (e.sel)
          2'd0:    begin ay = y_a; ayq = yq_a; acnt = cnt_a;          end
          2'd1:    begin ay = y_b; ayq = yq_b; acnt = cnt_b;          end
          default: begin ay = y_c; ayq = yq_c; acnt = {6'd0, cnt_c};  end
        endcase
        chk({e.name, "_y"},  {7'd0, ay},  {7'd0, e.exp_y});
        chk({e.name, "_yq"}, {7'd0, ayq}, {7'd0, e.exp_yq});
`ifdef SEQDET_COUNT_EN
        if (e.chk_cnt) begin
          chk({e.name, "_cnt"}, acnt, e.exp_cnt);
        end
`endif
      end
    end
  end

  // One observed cycle: drive inputs after the edge and push the expectation.
  task automatic step(input logic [1:0] sel, input logic d, input logic e,
                      input logic r, input logic c, input logic ey,
                      input logic eyq, input logic ck, input logic [7:0] ecnt,
                      input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    reset   = r;
    din     = d;
    cnt_clr = c;
    en_a    = (sel == 2'd0) & e;
    en_b    = (sel == 2'd1) & e;
    en_c    = (sel == 2'd2) & e;
    obs     = 1'b1;
    x.sel = sel; x.exp_y = ey; x.exp_yq = eyq; x.chk_cnt = ck;
    x.exp_cnt = ecnt; x.name = nm;
    sb.push_back(x);
  endtask

  // Enabled bit stream; bit n-1 of each vector is the first cycle.
  task automatic run_seq(input logic [1:0] sel, input int n, input logic [31:0] bits,
                         input logic [31:0] ys, input logic [31:0] yqs, input string nm);
    for (int i = 0; i < n; i++) begin
      step(sel, bits[n-1-i], 1'b1, 1'b0, 1'b0, ys[n-1-i], yqs[n-1-i], 1'b0, 8'd0, nm);
    end
  endtask

  task automatic do_reset(input logic [1:0] sel);
    step(sel, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "rst");
  endtask

  task automatic probe(input logic [1:0] sel, input logic eyq, input logic [7:0] ecnt,
                       input string nm);
    step(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eyq, 1'b1, ecnt, nm);
  endtask

  initial begin
    // Reset state while reset is still high from time zero.
    do_reset(2'd0);

    // Default pattern 11001, overlapping: detections on bits 5 and 9.
    ovl_mode = 1'b1;
    run_seq(2'd0, 9, 32'b110011001, 32'b000010001, 32'b000001000, "a_ovl");
    probe(2'd0, 1'b1, 8'd2, "a_ovl_end");

    // Same stream, non-overlapping: detection on bit 5 only.
    do_reset(2'd0);
    ovl_mode = 1'b0;
    run_seq(2'd0, 9, 32'b110011001, 32'b000010000, 32'b000001000, "a_novl");
    probe(2'd0, 1'b0, 8'd1, "a_novl_end");

    // ovl_mode switched to 1 mid-match: S is kept and the next detection overlaps.
    do_reset(2'd0);
    ovl_mode = 1'b0;
    run_seq(2'd0, 4, 32'b1100, 32'b0000, 32'b0000, "a_sw_pre");
    ovl_mode = 1'b1;
    run_seq(2'd0, 5, 32'b11001, 32'b10001, 32'b01000, "a_sw_post");
    probe(2'd0, 1'b1, 8'd2, "a_sw_end");

    // PATTERN 1010, overlapping: bits 4, 6, 8.
    do_reset(2'd1);
    ovl_mode = 1'b1;
    run_seq(2'd1, 8, 32'b10101010, 32'b00010101, 32'b00001010, "b_ovl");
    probe(2'd1, 1'b1, 8'd3, "b_ovl_end");

    // PATTERN 1010, non-overlapping: bits 4 and 8.
    do_reset(2'd1);
    ovl_mode = 1'b0;
    run_seq(2'd1, 8, 32'b10101010, 32'b00010001, 32'b00001000, "b_novl");
    probe(2'd1, 1'b1, 8'd2, "b_novl_end");

    // en=0 gaps hold state; y stays low even when din would complete the match.
    do_reset(2'd0);
    ovl_mode = 1'b1;
    run_seq(2'd0, 4, 32'b1100, 32'b0000, 32'b0000, "a_en_pre");
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "a_en_off1");
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "a_en_off2");
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "a_en_off3");
    step(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, "a_en_resume");
    probe(2'd0, 1'b1, 8'd1, "a_en_after");

    // Reset between bits 4 and 5 discards the partial match.
    do_reset(2'd0);
    run_seq(2'd0, 4, 32'b1100, 32'b0000, 32'b0000, "a_mr_pre");
    do_reset(2'd0);
    run_seq(2'd0, 1, 32'b1, 32'b0, 32'b0, "a_mr_bit5");
    run_seq(2'd0, 5, 32'b11001, 32'b00001, 32'b00000, "a_mr_next");
    probe(2'd0, 1'b1, 8'd1, "a_mr_end");

`ifdef SEQDET_COUNT_EN
    // CNT_W=2: five detections saturate at 3; clear beats a same-cycle detection.
    do_reset(2'd2);
    ovl_mode = 1'b1;
    run_seq(2'd2, 21, 32'b110011001100110011001, 32'b000010001000100010001,
            32'b000001000100010001000, "c_sat");
    probe(2'd2, 1'b1, 8'd3, "c_sat_end");
    run_seq(2'd2, 3, 32'b100, 32'b000, 32'b000, "c_clr_pre");
    step(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, "c_clr_det");
    probe(2'd2, 1'b1, 8'd0, "c_clr_end");
`endif

    @(posedge clk);
    #1;
    obs  = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    en_c = 1'b0;
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      chk("sb_leftover", 8'(sb.size()), 8'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time bound");
    $fatal(1, "timeout");
  end

endmodule
